bpu_2bit_btb: RTL and testbench

Parametrised branch prediction unit for the 5-stage pipeline: a direct-mapped branch target buffer with per-entry 2-bit saturating counters, looked up in Fetch and trained from Execute. It drives the next fetch PC and the Decode/Execute flush when the resolved path disagrees with the instruction already in Decode. An optional return address stack predicts `jalr` returns.

---
 rtl/bpu_if.sv | 36 +++
 rtl/bpu_2bit_btb.sv | 157 +++++++++++++++
 tb/tb_bpu_2bit_btb.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/bpu_if.sv
// Fetch/Decode/Execute signals between the pipeline and the branch predictor.
interface bpu_if;
  logic [31:0] pc_f;
  logic [31:0] instr_f;
  logic [31:0] pc_d;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_uncond;
  logic        upd_call;
  logic        upd_ret;
  logic [31:0] nxt_pc;
  logic        flush_d_e;
  logic        pred_taken_f;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;

  modport master (
    output pc_f, instr_f, pc_d,
    output upd_valid, upd_pc, upd_taken,
    output upd_target, upd_uncond,
    output upd_call, upd_ret,
    input  nxt_pc, flush_d_e, pred_taken_f,
    input  stat_branches, stat_mispred
  );

  modport slave (
    input  pc_f, instr_f, pc_d,
    input  upd_valid, upd_pc, upd_taken,
    input  upd_target, upd_uncond,
    input  upd_call, upd_ret,
    output nxt_pc, flush_d_e, pred_taken_f,
    output stat_branches, stat_mispred
  );
endinterface

// File: rtl/bpu_2bit_btb.sv
// Direct-mapped BTB with 2-bit counters plus redirect/flush logic.
// Define BPU_RAS_EN to add a return address stack for jalr returns.
module bpu_2bit_btb #(
  parameter int IDX_W     = 6,
  parameter int TAG_W     = 30 - IDX_W,
  parameter int RAS_DEPTH = 8
) (
  input logic  clk,
  input logic  rst,
  bpu_if.slave bus
);
  localparam int N = 1 << IDX_W;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic [N-1:0]     v_q;
  logic [TAG_W-1:0] tag_q [N];
  logic [31:0]      tgt_q [N];
  logic [1:0]       cnt_q [N];
  logic [31:0]      br_q, mp_q;

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             f_hit, u_hit, is_cf_f;
  logic             ras_hit;
  logic [31:0]      ras_top;
  logic             pred_taken;
  logic [31:0]      pred_pc, exp_pc;
  logic             flush;

  assign f_idx = bus.pc_f[IDX_W+1:2];
  assign u_idx = bus.upd_pc[IDX_W+1:2];
  assign f_tag = bus.pc_f[IDX_W+2 +: TAG_W];
  assign u_tag = bus.upd_pc[IDX_W+2 +: TAG_W];
  assign f_hit = v_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign u_hit = v_q[u_idx] && (tag_q[u_idx] == u_tag);

  always_comb begin
    is_cf_f = 1'b0;
    unique case (bus.instr_f[6:0])
      OP_BR, OP_JAL, OP_JALR: is_cf_f = 1'b1;
      default:                is_cf_f = 1'b0;
    endcase
  end

  // A live return prediction from the stack outranks the BTB.
  always_comb begin
    pred_taken = 1'b0;
    pred_pc    = bus.pc_f + 32'd4;
    if (!rst && ras_hit) begin
      pred_taken = 1'b1;
      pred_pc    = ras_top;
    end else if (!rst && is_cf_f && f_hit && cnt_q[f_idx][1]) begin
      pred_taken = 1'b1;
      pred_pc    = tgt_q[f_idx];
    end
  end

  assign exp_pc = bus.upd_taken ? bus.upd_target
                                : bus.upd_pc + 32'd4;
  assign flush  = bus.upd_valid && (bus.pc_d != exp_pc);

  assign bus.flush_d_e     = flush;
  assign bus.nxt_pc        = flush ? exp_pc : pred_pc;
  assign bus.pred_taken_f  = pred_taken;
  assign bus.stat_branches = br_q;
  assign bus.stat_mispred  = mp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < N; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        cnt_q[i] <= 2'b01;
      end
    end else if (bus.upd_valid) begin
      if (u_hit) begin
        if (bus.upd_uncond)
          cnt_q[u_idx] <= 2'b11;
        else if (bus.upd_taken && cnt_q[u_idx] != 2'b11)
          cnt_q[u_idx] <= cnt_q[u_idx] + 2'd1;
        else if (!bus.upd_taken && cnt_q[u_idx] != 2'b00)
          cnt_q[u_idx] <= cnt_q[u_idx] - 2'd1;
        if (bus.upd_taken)
          tgt_q[u_idx] <= bus.upd_target;
      end else if (bus.upd_taken) begin
        v_q[u_idx]   <= 1'b1;
        tag_q[u_idx] <= u_tag;
        tgt_q[u_idx] <= bus.upd_target;
        cnt_q[u_idx] <= bus.upd_uncond ? 2'b11 : 2'b10;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_q <= '0;
      mp_q <= '0;
    end else begin
      if (bus.upd_valid && br_q != '1)
        br_q <= br_q + 32'd1;
      if (flush && mp_q != '1)
        mp_q <= mp_q + 32'd1;
    end
  end

`ifdef BPU_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

  logic [31:0]   ras_q [RAS_DEPTH];
  logic [PW-1:0] ras_ptr, top_idx;
  logic [PW:0]   ras_cnt;
  logic          is_ret_f, do_push, do_pop;
  logic          unused_ok;

  assign unused_ok = ^{bus.instr_f[31:20], bus.instr_f[14:12]};
  assign is_ret_f  = (bus.instr_f[6:0] == OP_JALR)
                  && (bus.instr_f[11:7] == 5'd0)
                  && (bus.instr_f[19:15] == 5'd1
                   || bus.instr_f[19:15] == 5'd5);
  assign top_idx = ras_ptr - 1'b1;
  assign ras_top = ras_q[top_idx];
  assign ras_hit = is_ret_f && (ras_cnt != '0);
  assign do_push = bus.upd_valid && bus.upd_call;
  assign do_pop  = bus.upd_valid && bus.upd_ret
                && (ras_cnt != '0);

  // Pop+push from one instruction just rewrites the top slot.
  always_ff @(posedge clk) begin
    if (!rst && do_push)
      ras_q[do_pop ? top_idx : ras_ptr] <= bus.upd_pc + 32'd4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (do_pop && !do_push) begin
      ras_ptr <= top_idx;
      ras_cnt <= ras_cnt - 1'b1;
    end else if (do_push && !do_pop) begin
      ras_ptr <= ras_ptr + 1'b1;
      if (ras_cnt != FULL)
        ras_cnt <= ras_cnt + 1'b1;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{bus.upd_call, bus.upd_ret,
                       bus.instr_f[31:7]};
  assign ras_hit   = 1'b0;
  assign ras_top   = '0;
`endif
endmodule

// File: tb/tb_bpu_2bit_btb.sv
// Vector-table and scoreboard bench for bpu_2bit_btb, including
// RAS sequences when BPU_RAS_EN is defined.
module tb_bpu_2bit_btb;
  localparam logic [31:0] BEQ = 32'h0000_0063;
  localparam logic [31:0] JAL = 32'h0000_00EF;
  localparam logic [31:0] RET = 32'h0000_8067;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef BPU_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc_f, instr_f, pc_d;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        uu, uc, ur;
    logic        e_pred;
    logic [31:0] e_nxt;
    logic        e_flush;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bpu_if bus();

  bpu_2bit_btb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_br = 0;
  int exp_mp = 0;
  int vid    = 0;
  vec_t tv[$];
  vec_t sb_q[$];

  function automatic vec_t mk(
    input logic [31:0] pf, ins, pd,
    input logic uv, input logic [31:0] upc,
    input logic ut, input logic [31:0] tgt,
    input logic uu, uc, ur,
    input logic ep, input logic [31:0] en,
    input logic ef);
    vec_t v;
    v.pc_f = pf; v.instr_f = ins; v.pc_d = pd;
    v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = tgt;
    v.uu = uu; v.uc = uc; v.ur = ur;
    v.e_pred = ep; v.e_nxt = en; v.e_flush = ef;
    return v;
  endfunction

  function automatic vec_t idle(
    input logic [31:0] pf, ins,
    input logic ep, input logic [31:0] en);
    return mk(pf, ins, 32'h0, 0, 0, 0, 0, 0, 0, 0,
              ep, en, 1'b0);
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h",
               nm, vid, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.pc_f       = v.pc_f;
    bus.instr_f    = v.instr_f;
    bus.pc_d       = v.pc_d;
    bus.upd_valid  = v.uv;
    bus.upd_pc     = v.upc;
    bus.upd_taken  = v.ut;
    bus.upd_target = v.utgt;
    bus.upd_uncond = v.uu;
    bus.upd_call   = v.uc;
    bus.upd_ret    = v.ur;
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    drive(v);
    sb_q.push_back(v);
    @(negedge clk);
    e = sb_q.pop_front();
    chk("pred_taken_f", {31'b0, bus.pred_taken_f},
        {31'b0, e.e_pred});
    chk("nxt_pc", bus.nxt_pc, e.e_nxt);
    chk("flush_d_e", {31'b0, bus.flush_d_e},
        {31'b0, e.e_flush});
    chk("stat_branches", bus.stat_branches, exp_br);
    chk("stat_mispred", bus.stat_mispred, exp_mp);
    if (e.uv) exp_br++;
    if (e.e_flush) exp_mp++;
    @(posedge clk);
    #1;
    vid++;
  endtask

  initial begin
    drive(idle(32'h100, NOP, 1'b0, 32'h0));
    #2;
    chk("rst_pred", {31'b0, bus.pred_taken_f}, 32'h0);
    chk("rst_nxt", bus.nxt_pc, 32'h104);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stat_br", bus.stat_branches, 32'h0);
    chk("rst_stat_mp", bus.stat_mispred, 32'h0);
    rst = 1'b0;

    tv.push_back(mk(32'h100, BEQ, 32'hdead, 0, 0, 0, 0, 0, 0, 0,
                    0, 32'h104, 0));
    tv.push_back(mk(32'h104, NOP, 32'h104,
                    1, 32'h100, 1, 32'h80, 0, 0, 0,
                    0, 32'h80, 1));
    tv.push_back(idle(32'h100, BEQ, 1, 32'h80));
    tv.push_back(mk(32'h100, BEQ, 32'h80,
                    1, 32'h100, 0, 32'h0, 0, 0, 0,
                    1, 32'h104, 1));
    tv.push_back(idle(32'h100, BEQ, 0, 32'h104));
    tv.push_back(mk(32'h200, BEQ, 32'h300,
                    1, 32'h200, 1, 32'h300, 0, 0, 0,
                    0, 32'h204, 0));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(32'h200, BEQ, 32'h300,
                      1, 32'h200, 1, 32'h300, 0, 0, 0,
                      1, 32'h300, 0));
    for (int i = 0; i < 2; i++)
      tv.push_back(mk(32'h200, BEQ, 32'h204,
                      1, 32'h200, 0, 32'h0, 0, 0, 0,
                      1, 32'h300, 0));
    tv.push_back(idle(32'h200, BEQ, 0, 32'h204));
    tv.push_back(mk(32'h100, BEQ, 32'h80,
                    1, 32'h100, 1, 32'h80, 0, 0, 0,
                    0, 32'h104, 0));
    tv.push_back(mk(32'h100, BEQ, 32'h300,
                    1, 32'h200, 1, 32'h300, 0, 0, 0,
                    1, 32'h80, 0));
    tv.push_back(idle(32'h100, BEQ, 0, 32'h104));
    tv.push_back(idle(32'h200, BEQ, 1, 32'h300));
    tv.push_back(mk(32'h408, NOP, 32'h408,
                    1, 32'h404, 1, 32'h900, 1, 0, 0,
                    0, 32'h900, 1));
    tv.push_back(idle(32'h404, NOP, 0, 32'h408));
    tv.push_back(idle(32'h404, JAL, 1, 32'h900));
    tv.push_back(mk(32'h404, JAL, 32'h408,
                    1, 32'h404, 0, 32'h0, 0, 0, 0,
                    1, 32'h900, 0));
    tv.push_back(mk(32'h404, JAL, 32'h904,
                    1, 32'h404, 1, 32'h904, 1, 0, 0,
                    1, 32'h900, 0));
    tv.push_back(idle(32'h404, JAL, 1, 32'h904));

    foreach (tv[i]) apply(tv[i]);

    for (int i = 0; i < 9; i++)
      apply(mk(32'h700, NOP, 32'h2000,
               1, 32'h1000 + 32'(16 * i), 1, 32'h2000,
               1, 1, 0, 0, 32'h704, 0));
    for (int j = 0; j < 9; j++) begin
      logic ep;
      logic [31:0] en;
      ep = RAS && (j < 8);
      en = ep ? 32'h1084 - 32'(16 * j) : 32'h304C;
      apply(mk(32'h3048, RET, 32'h7000,
               1, 32'h3044, 1, 32'h7000, 1, 0, 1,
               ep, en, 0));
    end
    apply(mk(32'h700, NOP, 32'h2000,
             1, 32'h5000, 1, 32'h2000, 1, 1, 0,
             0, 32'h704, 0));
    apply(mk(32'h700, NOP, 32'h2000,
             1, 32'h6000, 1, 32'h2000, 1, 1, 1,
             0, 32'h704, 0));
    apply(mk(32'h3048, RET, 32'h7000,
             1, 32'h3044, 1, 32'h7000, 1, 0, 1,
             RAS, RAS ? 32'h6004 : 32'h304C, 0));
    apply(idle(32'h3048, RET, 0, 32'h304C));

    drive(idle(32'h404, JAL, 0, 32'h0));
    @(negedge clk);
    chk("pre_rst_pred", {31'b0, bus.pred_taken_f}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_pred", {31'b0, bus.pred_taken_f}, 32'h0);
    chk("async_rst_nxt", bus.nxt_pc, 32'h408);
    chk("async_rst_flush", {31'b0, bus.flush_d_e}, 32'h0);
    chk("async_rst_br", bus.stat_branches, 32'h0);
    chk("async_rst_mp", bus.stat_mispred, 32'h0);
    drive(mk(32'h404, JAL, 32'h0,
             1, 32'h404, 1, 32'h900, 1, 0, 0, 0, 0, 0));
    #1;
    chk("rst_flush_comb", {31'b0, bus.flush_d_e}, 32'h1);
    chk("rst_flush_nxt", bus.nxt_pc, 32'h900);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_br = 0;
    exp_mp = 0;
    apply(idle(32'h404, JAL, 0, 32'h408));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
